// File: rtl/irq_ctrl.sv
// Interrupt controller: sw/timer/external sources, local-bus registers, and a
// request/acknowledge/done handshake to a core without nesting.
module irq_ctrl #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NEXT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            int_timer,
  input  logic            int_sw,
  input  logic [NEXT-1:0] int_ext,
  input  logic            sel,
  input  logic [15:0]     addr,
  input  logic [3:0]      we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            irq_req,
  output logic [4:0]      irq_cause,
  input  logic            irq_ack,
  input  logic            irq_done
);

  localparam int unsigned EXT_LSB = 8;
  localparam logic [XLEN-1:0] EXT_FIELD = XLEN'(((64'd1 << NEXT) - 64'd1) << EXT_LSB);
  localparam logic [XLEN-1:0] IE_MASK   = EXT_FIELD | XLEN'(3);
  localparam logic [4:0] CAUSE_SW    = 5'd3;
  localparam logic [4:0] CAUSE_TIMER = 5'd7;
  localparam logic [4:0] CAUSE_EXT   = 5'd16;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] ie_q;
  logic [NEXT-1:0] pend_q, ext_prev_q;
  logic [4:0]      cause_reg_q;
  logic            gie_q;

  logic            bus_hit, wr_en, rd_en;
  logic [XLEN-1:0] wmask, wbits, rd_val;
  logic [NEXT-1:0] rise, ext_elig, w1c, ack_clr;
  logic [7:0]      ext_elig8, ack_clr8;
  logic            elig_sw, elig_tim, src_elig, ack_fire;
  logic            cand_valid;
  logic [4:0]      cand_cause;
  logic            irq_req_d;
  logic [4:0]      irq_cause_d;
  logic            unused_addr_lsb;

  assign unused_addr_lsb = ^addr[1:0];

  // Bus decode; byte lanes expanded into a bit mask
  assign bus_hit = sel && (addr[15:4] == 12'd0);
  assign wr_en   = bus_hit && (we != 4'd0);
  assign rd_en   = bus_hit && (we == 4'd0);
  assign wmask   = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  assign wbits   = wdata & wmask;
  assign w1c     = (wr_en && addr[3:2] == 2'd1) ? wbits[EXT_LSB +: NEXT] : '0;

  // A same-cycle edge counts as pending so it competes with level sources at once
  assign rise      = int_ext & ~ext_prev_q;
  assign ext_elig  = (pend_q | rise) & ie_q[EXT_LSB +: NEXT];
  assign ext_elig8 = 8'(ext_elig);
  assign elig_sw   = int_sw & ie_q[0];
  assign elig_tim  = int_timer & ie_q[1];

  assign ack_fire = (state_q == S_REQ) && irq_ack;
  assign ack_clr8 = {7'd0, ack_fire & irq_cause[4]} << irq_cause[2:0];
  assign ack_clr  = ack_clr8[NEXT-1:0];

  // Priority pick: later assignments win, so lowest ext index ends up on top
  always_comb begin
    cand_valid = 1'b0;
    cand_cause = '0;
    if (elig_tim) begin
      cand_valid = 1'b1;
      cand_cause = CAUSE_TIMER;
    end
    if (elig_sw) begin
      cand_valid = 1'b1;
      cand_cause = CAUSE_SW;
    end
    for (int i = int'(NEXT) - 1; i >= 0; i--) begin
      if (ext_elig[i]) begin
        cand_valid = 1'b1;
        cand_cause = CAUSE_EXT + 5'(i);
      end
    end
  end

  // Whether the source latched in irq_cause is still eligible
  always_comb begin
    src_elig = 1'b0;
    case (irq_cause)
      CAUSE_SW:    src_elig = elig_sw;
      CAUSE_TIMER: src_elig = elig_tim;
      default:     src_elig = irq_cause[4] && ext_elig8[irq_cause[2:0]];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (gie_q && cand_valid) state_d = S_REQ;
      S_REQ: begin
        if (irq_ack)                    state_d = S_SERVICE;
        else if (!gie_q || !src_elig)   state_d = S_IDLE;
      end
      S_SERVICE: if (irq_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Cause is captured on entry to REQ and held; zero outside REQ
  always_comb begin
    irq_req_d   = 1'b0;
    irq_cause_d = '0;
    if (state_d == S_REQ) begin
      irq_req_d   = 1'b1;
      irq_cause_d = (state_q == S_IDLE) ? cand_cause : irq_cause;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_req   <= 1'b0;
      irq_cause <= '0;
    end else begin
      irq_req   <= irq_req_d;
      irq_cause <= irq_cause_d;
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr[3:2])
      2'd0: rd_val = ie_q;
      2'd1: rd_val = (XLEN'(pend_q) << EXT_LSB) | XLEN'({int_timer, int_sw});
      2'd2: rd_val = XLEN'(cause_reg_q);
      2'd3: rd_val = XLEN'(gie_q);
      default: rd_val = '0;
    endcase
  end

  // Register file, sticky pending bits and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_q        <= '0;
      pend_q      <= '0;
      ext_prev_q  <= int_ext;
      cause_reg_q <= '0;
      gie_q       <= 1'b0;
      rdata       <= '0;
    end else begin
      ext_prev_q <= int_ext;
      pend_q     <= (pend_q & ~(w1c | ack_clr)) | rise;
      if (wr_en && addr[3:2] == 2'd0)
        ie_q <= ((ie_q & ~wmask) | wbits) & IE_MASK;
      if (wr_en && addr[3:2] == 2'd3 && we[0])
        gie_q <= wdata[0];
      if (ack_fire)
        cause_reg_q <= irq_cause;
      rdata <= rd_en ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus randomized traffic, all checked
// every cycle against a behavioural model of the controller.
module tb_irq_ctrl;
  localparam int NEXT = 8;

  logic            clk = 1'b0;
  logic            rst, int_timer, int_sw;
  logic [NEXT-1:0] int_ext;
  logic            sel;
  logic [15:0]     addr;
  logic [3:0]      we;
  logic [31:0]     wdata, rdata;
  logic            irq_req;
  logic [4:0]      irq_cause;
  logic            irq_ack, irq_done;

  irq_ctrl #(.XLEN(32), .NEXT(NEXT)) dut (
    .clk(clk), .rst(rst), .int_timer(int_timer), .int_sw(int_sw),
    .int_ext(int_ext), .sel(sel), .addr(addr), .we(we), .wdata(wdata),
    .rdata(rdata), .irq_req(irq_req), .irq_cause(irq_cause),
    .irq_ack(irq_ack), .irq_done(irq_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: mode 0 idle, 1 requesting, 2 in handler
  int              m_mode;
  logic [4:0]      m_cause, m_cause_reg;
  logic [31:0]     m_ie, m_rdata, ie_mask, bmask;
  logic            m_gie;
  logic [NEXT-1:0] m_pend, m_prev, rise_m, pend_n;
  bit              m_valid = 1'b0;
  bit              w_ok, clr;
  int              best, ack_code;
  int              prio[$];

  function automatic bit eligible(input int code, input logic [NEXT-1:0] rs);
    if (code == 3) return int_sw && m_ie[0];
    if (code == 7) return int_timer && m_ie[1];
    if (code >= 16 && code < 16 + NEXT)
      return (m_pend[code-16] || rs[code-16]) && m_ie[code-8];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_cause = '0; m_cause_reg = '0; m_ie = '0; m_gie = 1'b0;
      m_pend = '0; m_prev = int_ext; m_rdata = '0; m_valid = 1'b1;
    end else begin
      rise_m = int_ext & ~m_prev;
      best = 0;
      foreach (prio[k]) if (best == 0 && eligible(prio[k], rise_m)) best = prio[k];
      ack_code = -1;
      w_ok = sel && (addr[15:4] == 12'd0);
      m_rdata = '0;
      if (w_ok && we == 4'd0) begin
        case (addr[3:2])
          2'd0: m_rdata = m_ie;
          2'd1: begin
            m_rdata[0] = int_sw;
            m_rdata[1] = int_timer;
            for (int i = 0; i < NEXT; i++) m_rdata[8+i] = m_pend[i];
          end
          2'd2: m_rdata = 32'(m_cause_reg);
          default: m_rdata = 32'(m_gie);
        endcase
      end
      case (m_mode)
        0: if (m_gie && best != 0) begin m_mode = 1; m_cause = 5'(best); end
        1: begin
          if (irq_ack) begin
            m_mode = 2; m_cause_reg = m_cause; ack_code = int'(m_cause); m_cause = '0;
          end else if (!m_gie || !eligible(int'(m_cause), rise_m)) begin
            m_mode = 0; m_cause = '0;
          end
        end
        default: if (irq_done) m_mode = 0;
      endcase
      for (int b = 0; b < 4; b++) bmask[8*b +: 8] = we[b] ? 8'hFF : 8'h00;
      for (int i = 0; i < NEXT; i++) begin
        clr = (w_ok && we != 4'd0 && addr[3:2] == 2'd1 && bmask[8+i] && wdata[8+i])
              || (ack_code == 16 + i);
        pend_n[i] = rise_m[i] || (m_pend[i] && !clr);
      end
      if (w_ok && we != 4'd0 && addr[3:2] == 2'd0)
        m_ie = ((m_ie & ~bmask) | (wdata & bmask)) & ie_mask;
      if (w_ok && we[0] && addr[3:2] == 2'd3) m_gie = wdata[0];
      m_pend = pend_n;
      m_prev = int_ext;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("irq_req", 32'(irq_req), 32'(m_mode == 1));
      check("irq_cause", 32'(irq_cause), 32'(m_cause));
      check("rdata", rdata, m_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    sel = 1'b1; we = 4'hF; addr = a; wdata = d;
    tick();
    sel = 1'b0; we = 4'h0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    sel = 1'b1; we = 4'h0; addr = a;
    tick();
    d = rdata;
    sel = 1'b0;
  endtask

  logic [31:0] d;

  initial begin
    ie_mask = 32'h3;
    for (int i = 0; i < NEXT; i++) ie_mask[8+i] = 1'b1;
    for (int i = 0; i < NEXT; i++) prio.push_back(16 + i);
    prio.push_back(3);
    prio.push_back(7);

    rst = 1'b1; int_timer = 1'b0; int_sw = 1'b0; int_ext = '0;
    sel = 1'b0; addr = '0; we = '0; wdata = '0; irq_ack = 1'b0; irq_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_irq_req", 32'(irq_req), 32'd0);
    check("rst_irq_cause", 32'(irq_cause), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rd(16'h0, d);  check("rst_ie", d, 32'd0);
    rd(16'hC, d);  check("rst_ctrl", d, 32'd0);

    // Timer request, ack, CAUSE readback
    do_reset();
    wr(16'h0, 32'h2); wr(16'hC, 32'h1);
    int_timer = 1'b1; tick();
    check("t_req", 32'(irq_req), 32'd1);
    check("t_cause", 32'(irq_cause), 32'd7);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("t_ack_req", 32'(irq_req), 32'd0);
    rd(16'h8, d); check("t_cause_reg", d, 32'd7);
    int_timer = 1'b0; irq_done = 1'b1; tick(); irq_done = 1'b0;

    // Simultaneous sources: ext0 first, then sw
    do_reset();
    wr(16'h0, 32'h103); wr(16'hC, 32'h1);
    int_timer = 1'b1; int_sw = 1'b1; int_ext[0] = 1'b1; tick();
    check("prio_ext0", 32'(irq_cause), 32'd16);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    check("prio_gap", 32'(irq_req), 32'd0);
    tick();
    check("prio_sw_req", 32'(irq_req), 32'd1);
    check("prio_sw", 32'(irq_cause), 32'd3);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    int_sw = 1'b0; int_timer = 1'b0; int_ext = '0;
    irq_done = 1'b1; tick(); irq_done = 1'b0;

    // Withdraw when timer drops
    do_reset();
    wr(16'h0, 32'h2); wr(16'hC, 32'h1);
    int_timer = 1'b1; tick();
    check("wd_cause", 32'(irq_cause), 32'd7);
    int_timer = 1'b0; tick();
    check("wd_req", 32'(irq_req), 32'd0);
    check("wd_cause0", 32'(irq_cause), 32'd0);
    tick();
    check("wd_idle", 32'(irq_req), 32'd0);

    // Set beats W1C on the same edge
    do_reset();
    int_ext[2] = 1'b1; tick(); int_ext[2] = 1'b0; tick();
    rd(16'h4, d); check("ip_set", d, 32'h400);
    int_ext[2] = 1'b1; sel = 1'b1; we = 4'hF; addr = 16'h4; wdata = 32'h400;
    tick();
    sel = 1'b0; we = 4'h0;
    rd(16'h4, d); check("ip_set_wins", d, 32'h400);
    wr(16'h4, 32'h400);
    rd(16'h4, d); check("ip_w1c", d, 32'h0);
    int_ext = '0;

    // No nesting while in the handler
    do_reset();
    wr(16'h0, 32'h3); wr(16'hC, 32'h1);
    int_timer = 1'b1; tick();
    check("svc_cause", 32'(irq_cause), 32'd7);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    int_timer = 1'b0; int_sw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("svc_hold", 32'(irq_req), 32'd0);
    end
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    check("svc_done", 32'(irq_req), 32'd0);
    tick();
    check("svc_sw_req", 32'(irq_req), 32'd1);
    check("svc_sw_cause", 32'(irq_cause), 32'd3);
    int_sw = 1'b0; tick();

    // Reset in REQ with ext1 held high
    do_reset();
    wr(16'h0, 32'h200); wr(16'hC, 32'h1);
    int_ext[1] = 1'b1; tick();
    check("rr_cause", 32'(irq_cause), 32'd17);
    rst = 1'b1; tick();
    check("rr_req", 32'(irq_req), 32'd0);
    check("rr_cause0", 32'(irq_cause), 32'd0);
    check("rr_rdata", rdata, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("rr_quiet", 32'(irq_req), 32'd0);
    rd(16'h4, d); check("rr_ip", d, 32'd0);
    rd(16'h0, d); check("rr_ie", d, 32'd0);
    int_ext = '0;

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom % 300) == 0;
      if ($urandom % 20 == 0) int_sw = ~int_sw;
      if ($urandom % 20 == 0) int_timer = ~int_timer;
      int_ext = int_ext ^ (NEXT'($urandom) & NEXT'($urandom) & NEXT'($urandom));
      sel = ($urandom % 3) == 0;
      addr = ($urandom % 16 == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      we = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
      wdata = $urandom;
      irq_ack = irq_req ? ($urandom % 3 == 0) : ($urandom % 40 == 0);
      irq_done = ($urandom % 6) == 0;
      tick();
    end
    rst = 1'b0; sel = 1'b0; we = 4'h0; irq_ack = 1'b0; irq_done = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter XLEN, 32, local bus data width; only 32 supported.
REQ-002 Parameter NEXT, 8, number of external interrupt inputs (1..8).
REQ-003 Port clk  in  1  single clock; all logic on rising edge.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Port int_timer  in  1  timer interrupt level from the timer block.
REQ-006 Port int_sw  in  1  software interrupt level (timer block msip bit 0).
REQ-007 Port int_ext  in  NEXT  external interrupt lines, rising-edge sensitive.
REQ-008 Port sel  in  1  local bus select for this block.
REQ-009 Port addr  in  16  local bus byte address.
REQ-010 Port we  in  4  local bus byte write enables; 0 = read.
REQ-011 Port wdata  in  XLEN  local bus write data.
REQ-012 Port rdata  out  XLEN  local bus read data.
REQ-013 Port irq_req  out  1  interrupt request to core.
REQ-014 Port irq_cause  out  5  cause code of the request, valid while irq_req=1.
REQ-015 Port irq_ack  in  1  core accepts request (one-cycle pulse).
REQ-016 Port irq_done  in  1  core finished handler (mret, one-cycle pulse).

Function
REQ-017 Register map, addr[15:4]=0 required, decode addr[3:2]: 0x0 IE, 0x4 IP, 0x8 CAUSE, 0xC CTRL; other addresses read 0, writes ignored.
REQ-018 IE: bit0 sw enable, bit1 timer enable, bits[8+NEXT-1:8] ext enables; R/W, other bits read 0.
REQ-019 IP: bit0 = int_sw, bit1 = int_timer (live, read-only), bits[8+NEXT-1:8] ext pending (sticky); writing 1 to an ext bit clears it, writing 0 no effect.
REQ-020 CAUSE: read-only, last acknowledged cause in bits[4:0].
REQ-021 CTRL: bit0 global enable GIE, R/W.
REQ-022 Writes honour byte enables we[3:0]; write takes effect on the clock edge with sel=1.
REQ-023 Read: sel=1, we=0 -> rdata registered, valid the following cycle; rdata=0 in all other cycles.
REQ-024 Ext pending bit n set one cycle after a rising edge on int_ext[n] (previous-sample register); set wins over same-cycle W1C or ack clear.
REQ-025 Eligible = pending AND enabled; candidate priority: ext lowest index highest, then sw, then timer.
REQ-026 Cause codes: ext n -> 16+n, sw -> 3, timer -> 7.
REQ-027 FSM states IDLE, REQ, SERVICE.
REQ-028 IDLE -> REQ when GIE=1 and any eligible; irq_cause latched from the highest-priority candidate, irq_req=1 from the next cycle.
REQ-029 In REQ irq_cause held stable; a newly arriving higher-priority source does not change it.
REQ-030 REQ -> SERVICE on irq_ack=1; CAUSE register updated; if cause is ext n, its pending bit cleared the same edge.
REQ-031 REQ -> IDLE (withdraw) when, without irq_ack, the latched source stops being eligible or GIE=0; irq_ack in the same cycle wins.
REQ-032 SERVICE: irq_req=0, no new requests (no nesting); SERVICE -> IDLE on irq_done.
REQ-033 irq_ack outside REQ and irq_done outside SERVICE ignored.
REQ-034 irq_cause = 0 whenever irq_req = 0.

Reset
REQ-035 On rst: FSM IDLE, IE=0, ext pending=0, CAUSE=0, GIE=0, edge-detect registers loaded with current int_ext (no spurious edge), irq_req=0, irq_cause=0, rdata=0.
REQ-036 rst asserted in REQ or SERVICE aborts immediately; rst wins over every other event in the same cycle.

Verification
REQ-037 IE=0x2, GIE=1, int_timer 0->1 -> irq_req=1 with irq_cause=7 next cycle; irq_ack -> irq_req=0, CAUSE reads 7.
REQ-038 IE=0x103, GIE=1, int_timer, int_sw and rising edge int_ext[0] same cycle -> irq_cause=16; after ack and irq_done, irq_cause=3 follows.
REQ-039 In REQ with cause 7, int_timer drops with no ack -> irq_req=0 next cycle, FSM IDLE.
REQ-040 Pending ext[2] set; write IP=0x400 same cycle as new rising edge on int_ext[2] -> IP bit10 remains 1.
REQ-041 In SERVICE, int_sw asserted with IE bit0=1 -> irq_req stays 0 until irq_done, then asserts with cause 3.
REQ-042 rst pulse while in REQ with int_ext[1] held high -> all outputs 0, IP ext bits 0, no request after rst release.
